// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Conditions the raw board slide switches before they reach the switch-to-LED
//   path. Each bit goes through its own two-flop synchroniser and then its own
//   bounce filter, so activity on one switch never delays another.
//
//   A new level is accepted only after it has been seen at the synchroniser
//   output for DEBOUNCE_CYCLES consecutive clocks. Any return to the current
//   clean level restarts the count.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   sw          raw asynchronous switch inputs
//   sw_clean    debounced switch levels (registered)
//   sw_rise     one-cycle pulse per bit when sw_clean[i] goes 0->1 (registered)
//   sw_fall     one-cycle pulse per bit when sw_clean[i] goes 1->0 (registered)
//   any_change  OR of every sw_rise/sw_fall bit, in the same cycle (registered)
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // The count that, once reached with the input still different, accepts the
  // new level on the following edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_sync_q;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic             any_q,   any_d;

  // Two-flop synchroniser: nothing may sit between sw_meta_q and sw_sync_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= {WIDTH{1'b0}};
      sw_sync_q <= {WIDTH{1'b0}};
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Per-bit filter: count consecutive cycles the synchronised level differs
  // from the clean level and accept it once the count reaches the last step.
  always_comb begin
    clean_d = clean_q;
    rise_d  = {WIDTH{1'b0}};
    fall_d  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sw_sync_q[i] == clean_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] >= CNT_LAST) begin
        // >= rather than == so a corrupted counter still lands on an accept
        // and returns to zero instead of running past the limit.
        clean_d[i] = sw_sync_q[i];
        cnt_d[i]   = CNT_ZERO;
        rise_d[i]  = sw_sync_q[i];
        fall_d[i]  = ~sw_sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      clean_q <= {WIDTH{1'b0}};
      rise_q  <= {WIDTH{1'b0}};
      fall_q  <= {WIDTH{1'b0}};
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign sw_clean   = clean_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//   Drives two debouncer instances (DEBOUNCE_CYCLES = 4 and = 1) from the same
//   switch/reset stimulus and compares every output after every clock edge
//   against a reference model.
//
//   The model keeps the full history of what was applied on each edge and
//   decides acceptance from the rule "the synchronised value seen on each of
//   the last D edges differed from the clean level, with no reset in that
//   window". The synchronised value seen at edge n is the switch value applied
//   at edge n-2, unless a reset edge cleared the chain in between.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W    = 16;
  localparam int MAXE = 8192;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw;

  logic [W-1:0] clean4, rise4, fall4;
  logic         any4;
  logic [W-1:0] clean1, rise1, fall1;
  logic         any1;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .sw_clean   (clean4),
    .sw_rise    (rise4),
    .sw_fall    (fall4),
    .any_change (any4)
  );

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .sw_clean   (clean1),
    .sw_rise    (rise1),
    .sw_fall    (fall1),
    .any_change (any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus history, one entry per clock edge.
  logic [W-1:0] sw_at  [MAXE];
  logic         rst_at [MAXE];
  int           edge_n;

  // Model state for each instance.
  logic [W-1:0] m_clean4, m_rise4, m_fall4;
  logic [W-1:0] m_clean1, m_rise1, m_fall1;

  int n_checks;
  int n_fails;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  // Value held by the synchroniser output just before edge m.
  function automatic logic [W-1:0] sync_seen(input int m);
    if (m < 2) return {W{1'b0}};
    if (rst_at[m-1] || rst_at[m-2]) return {W{1'b0}};
    return sw_at[m-2];
  endfunction

  task automatic model_edge(input int d, input int e, input logic [W-1:0] clean_in,
                            output logic [W-1:0] clean_out, output logic [W-1:0] rise,
                            output logic [W-1:0] fall);
    logic [W-1:0] s;
    bit ok;
    clean_out = clean_in;
    rise      = {W{1'b0}};
    fall      = {W{1'b0}};
    if (rst_at[e]) begin
      clean_out = {W{1'b0}};
    end else begin
      for (int i = 0; i < W; i++) begin
        ok = 1'b1;
        for (int j = 0; j < d; j++) begin
          if (e - j < 0) begin
            ok = 1'b0;
          end else if (rst_at[e-j]) begin
            ok = 1'b0;
          end else begin
            s = sync_seen(e - j);
            if (s[i] == clean_in[i]) ok = 1'b0;
          end
        end
        if (ok) begin
          clean_out[i] = ~clean_in[i];
          rise[i]      = ~clean_in[i];
          fall[i]      = clean_in[i];
        end
      end
    end
  endtask

  // One clock: apply inputs away from the edge, then check just after it.
  task automatic tick(input logic r, input logic [W-1:0] s);
    logic [W-1:0] c, ri, fa;
    if (edge_n >= MAXE) begin
      $display("FAIL history_overflow: edge %0d exceeds %0d", edge_n, MAXE);
      $fatal(1);
    end
    @(negedge clk);
    reset = r;
    sw    = s;
    sw_at[edge_n]  = s;
    rst_at[edge_n] = r;
    @(posedge clk);
    #1;
    model_edge(4, edge_n, m_clean4, c, ri, fa);
    m_clean4 = c; m_rise4 = ri; m_fall4 = fa;
    model_edge(1, edge_n, m_clean1, c, ri, fa);
    m_clean1 = c; m_rise1 = ri; m_fall1 = fa;
    check_eq("clean_d4", clean4, m_clean4);
    check_eq("rise_d4",  rise4,  m_rise4);
    check_eq("fall_d4",  fall4,  m_fall4);
    check_eq("any_d4",   {{(W-1){1'b0}}, any4}, {{(W-1){1'b0}}, |(m_rise4 | m_fall4)});
    check_eq("clean_d1", clean1, m_clean1);
    check_eq("rise_d1",  rise1,  m_rise1);
    check_eq("fall_d1",  fall1,  m_fall1);
    check_eq("any_d1",   {{(W-1){1'b0}}, any1}, {{(W-1){1'b0}}, |(m_rise1 | m_fall1)});
    edge_n++;
  endtask

  task automatic hold(input logic [W-1:0] s, input int n);
    for (int k = 0; k < n; k++) tick(1'b0, s);
  endtask

  logic [W-1:0] cur;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    edge_n   = 0;
    m_clean4 = '0; m_rise4 = '0; m_fall4 = '0;
    m_clean1 = '0; m_rise1 = '0; m_fall1 = '0;
    reset    = 1'b1;
    sw       = 16'hFFFF;

    // Reset with all switches high, then release: edge k is the first tick.
    for (int k = 0; k < 3; k++) tick(1'b1, 16'hFFFF);
    check_eq("reset_clean", clean4, 16'h0000);
    check_eq("reset_rise",  rise4,  16'h0000);
    tick(1'b0, 16'hFFFF);                       // edge k
    tick(1'b0, 16'hFFFF);                       // edge k+1
    check_eq("rel_d1_k1", rise1, 16'h0000);
    tick(1'b0, 16'hFFFF);                       // edge k+2
    check_eq("rel_d1_k2", rise1, 16'hFFFF);
    tick(1'b0, 16'hFFFF);                       // edge k+3
    tick(1'b0, 16'hFFFF);                       // edge k+4
    check_eq("rel_d4_k4", rise4, 16'h0000);
    tick(1'b0, 16'hFFFF);                       // edge k+5
    check_eq("rel_d4_k5_rise",  rise4, 16'hFFFF);
    check_eq("rel_d4_k5_clean", clean4, 16'hFFFF);
    check_eq("rel_d4_k5_any", {15'd0, any4}, 16'h0001);
    tick(1'b0, 16'hFFFF);                       // edge k+6
    check_eq("rel_d4_k6", rise4, 16'h0000);

    // All low, then a clean step on bit 3.
    hold(16'h0000, 8);
    cur = 16'h0008;
    hold(cur, 8);
    check_eq("step_bit3", clean4, 16'h0008);

    // Bounce on bit 7, then settle high.
    cur[7] = 1'b1; tick(1'b0, cur);
    cur[7] = 1'b0; tick(1'b0, cur);
    cur[7] = 1'b1; tick(1'b0, cur);
    cur[7] = 1'b0; tick(1'b0, cur);
    cur[7] = 1'b1;
    hold(cur, 8);

    // Glitch on bit 0 shorter than the filter window.
    cur[0] = 1'b1; hold(cur, 3);
    cur[0] = 1'b0; hold(cur, 8);
    check_eq("glitch_bit0", {15'd0, clean4[0]}, 16'h0000);

    // Simultaneous opposite transitions on bits 15 and 1.
    cur[15] = 1'b1; hold(cur, 8);
    cur[15] = 1'b0; cur[1] = 1'b1; hold(cur, 8);

    // Reset in the middle of a count on bit 5.
    cur[5] = 1'b1; hold(cur, 4);
    tick(1'b1, cur);
    hold(cur, 10);

    // Random switching with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      end
      tick(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, cur);
    end
    // Quiet tail so every pending level gets accepted.
    hold(cur, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
